// File: rtl/image_line_feeder_pkg.sv
// Shared image-stream definitions: default frame geometry, line-buffer depth,
// pixel and credit types, and the feeder state encoding.
package image_line_feeder_pkg;

  localparam int IMG_WIDTH_DEF  = 512;
  localparam int IMG_HEIGHT_DEF = 512;
  localparam int LINE_BUF_DEPTH = 4;
  localparam int PIXEL_W        = 8;
  localparam int CREDIT_W       = 3;

  typedef logic [PIXEL_W-1:0]  pixel_t;
  typedef logic [CREDIT_W-1:0] credit_t;

  localparam credit_t CREDIT_MAX  = 3'd7;
  localparam credit_t CREDIT_ZERO = 3'd0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEND  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } feed_state_t;

  // Clamp an integer row count into the range the credit counter can hold.
  function automatic credit_t credit_clamp(input int n);
    credit_t v;
    if (n > 7) begin
      v = CREDIT_MAX;
    end else if (n < 0) begin
      v = CREDIT_ZERO;
    end else begin
      v = credit_t'(n);
    end
    return v;
  endfunction

endpackage

// File: rtl/image_line_feeder_credit.sv
// Saturating row-credit counter: load on frame start, +1 per consumed-row
// pulse, -1 per row start. Also exposes the value it will take next edge so
// the row-end decision can account for a same-cycle credit.
module line_credit_counter
  import image_line_feeder_pkg::*;
(
  input  logic    i_clk,
  input  logic    i_rst,
  input  logic    i_load,
  input  credit_t i_load_val,
  input  logic    i_inc,
  input  logic    i_dec,
  output credit_t o_count,
  output credit_t o_count_next
);

  credit_t r_count;
  credit_t w_next;

  // Next credit value: load wins, inc/dec cancel, saturate at max, floor at zero.
  always_comb begin
    w_next = r_count;
    if (i_load) begin
      w_next = i_load_val;
    end else if (i_inc && !i_dec) begin
      if (r_count != CREDIT_MAX) begin
        w_next = r_count + 3'd1;
      end else begin
        w_next = r_count;
      end
    end else if (i_dec && !i_inc) begin
      if (r_count != CREDIT_ZERO) begin
        w_next = r_count - 3'd1;
      end else begin
        w_next = r_count;
      end
    end else begin
      w_next = r_count;
    end
  end

  // Credit register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= CREDIT_ZERO;
    end else begin
      r_count <= w_next;
    end
  end

  assign o_count      = r_count;
  assign o_count_next = w_next;

endmodule

// File: rtl/image_line_feeder.sv
// Frame-memory to line-buffer pixel source. Reads the frame in raster order,
// one row per credit; credits are preloaded at start and replenished by the
// window controller's row-consumed pulse. Memory read latency is one cycle and
// the pixel output is registered, so a read at cycle N is presented at N+2.
module image_line_feeder
  import image_line_feeder_pkg::*;
#(
  parameter int IMG_WIDTH     = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT    = IMG_HEIGHT_DEF,
  parameter int PRELOAD_LINES = LINE_BUF_DEPTH,
  parameter int ADDR_W        = 18
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_intr,
  output logic              o_mem_rd_en,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [7:0]        i_mem_data,
  output logic [7:0]        o_pixel_data,
  output logic              o_pixel_data_valid,
  output logic              o_busy,
  output logic              o_done
);

  localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_ZERO = '0;
  localparam credit_t PRELOAD_CREDITS = credit_clamp(PRELOAD_LINES);

  feed_state_t       r_state;
  feed_state_t       w_state_next;
  logic [COL_W-1:0]  r_col;
  logic [ROW_W-1:0]  r_row;
  logic [ADDR_W-1:0] r_addr;
  logic              r_drain;
  logic              r_rd_d;
  pixel_t            r_pixel;
  logic              r_pixel_valid;

  logic              w_rd_en;
  logic              w_load;
  logic              w_intr_ok;
  logic              w_row_start;
  logic              w_col_last;
  credit_t           w_credit;
  credit_t           w_credit_next;

  assign w_rd_en     = (r_state == ST_SEND);
  assign w_load      = (r_state == ST_IDLE) && i_start;
  assign w_intr_ok   = (r_state == ST_SEND) || (r_state == ST_WAIT);
  assign w_row_start = w_rd_en && (r_col == COL_ZERO);
  assign w_col_last  = (r_col == COL_LAST);

  line_credit_counter u_credit (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_load       (w_load),
    .i_load_val   (PRELOAD_CREDITS),
    .i_inc        (i_intr && w_intr_ok),
    .i_dec        (w_row_start),
    .o_count      (w_credit),
    .o_count_next (w_credit_next)
  );

  // Next-state selection; the row-end choice uses the post-update credit so a
  // pulse arriving on the last column keeps the stream gap-free.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          if (PRELOAD_CREDITS != CREDIT_ZERO) begin
            w_state_next = ST_SEND;
          end else begin
            w_state_next = ST_WAIT;
          end
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (w_col_last) begin
          if (r_row == ROW_LAST) begin
            w_state_next = ST_DRAIN;
          end else if (w_credit_next != CREDIT_ZERO) begin
            w_state_next = ST_SEND;
          end else begin
            w_state_next = ST_WAIT;
          end
        end else begin
          w_state_next = ST_SEND;
        end
      end
      ST_WAIT: begin
        if (w_credit != CREDIT_ZERO) begin
          w_state_next = ST_SEND;
        end else begin
          w_state_next = ST_WAIT;
        end
      end
      ST_DRAIN: begin
        if (r_drain) begin
          w_state_next = ST_DONE;
        end else begin
          w_state_next = ST_DRAIN;
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Raster position: column/row/linear address advance on every read.
  always_ff @(posedge i_clk) begin
    if (i_rst || w_load) begin
      r_col  <= '0;
      r_row  <= '0;
      r_addr <= '0;
    end else if (w_rd_en) begin
      r_addr <= r_addr + ADDR_W'(1);
      if (w_col_last) begin
        r_col <= '0;
        r_row <= r_row + ROW_W'(1);
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end
  end

  // Two-cycle drain timer: toggles through DRAIN so the last pixel lands first.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_drain <= 1'b0;
    end else if (r_state == ST_DRAIN) begin
      r_drain <= !r_drain;
    end else begin
      r_drain <= 1'b0;
    end
  end

  // Output pipeline: delayed strobe qualifies memory data; pixel holds when idle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_d        <= 1'b0;
      r_pixel_valid <= 1'b0;
      r_pixel       <= 8'h00;
    end else begin
      r_rd_d        <= w_rd_en;
      r_pixel_valid <= r_rd_d;
      if (r_rd_d) begin
        r_pixel <= i_mem_data;
      end
    end
  end

  assign o_mem_rd_en        = w_rd_en;
  assign o_mem_addr         = r_addr;
  assign o_pixel_data       = r_pixel;
  assign o_pixel_data_valid = r_pixel_valid;
  assign o_busy             = (r_state != ST_IDLE);
  assign o_done             = (r_state == ST_DONE);

endmodule
